// File: rtl/dcache_refill_ctrl_if.sv
// Main-memory request/acknowledge port of the data-cache refill controller.
// master: the refill controller issuing transactions; slave: the memory side.
interface dcache_refill_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss handler: optional dirty-victim writeback followed by an
// optional line fill over a req/ack memory port, with pipeline stall and
// saturating miss / writeback performance counters.
module dcache_refill_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss,
  input  logic              miss_rd,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt,
  dcache_refill_ctrl_if.master mem
);

  // S_GAP is the one idle-bus cycle separating the writeback from the read.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_GAP,
    S_RD,
    S_FILL
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic              miss_rd_q, miss_rd_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]  wb_cnt_q, wb_cnt_d;

  logic miss_accept;
  logic wb_done;

  // State and captured miss context; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      miss_addr_q <= '0;
      miss_rd_q   <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
      miss_cnt_q  <= '0;
      wb_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      miss_rd_q   <= miss_rd_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      fill_addr_q <= fill_addr_d;
      fill_data_q <= fill_data_d;
      miss_cnt_q  <= miss_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
    end
  end

  // Next-state, miss capture, fill capture and memory/cache-side outputs.
  always_comb begin
    state_d       = state_q;
    miss_addr_d   = miss_addr_q;
    miss_rd_d     = miss_rd_q;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    fill_addr_d   = fill_addr_q;
    fill_data_d   = fill_data_q;
    miss_accept   = 1'b0;
    wb_done       = 1'b0;
    stall         = 1'b1;
    fill_valid    = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;

    case (state_q)
      S_IDLE: begin
        stall = miss;
        if (miss) begin
          miss_accept = 1'b1;
          miss_addr_d = miss_addr;
          miss_rd_d   = miss_rd;
          wb_addr_d   = wb_addr;
          wb_data_d   = wb_data;
          if (wb_req)       state_d = S_WB;
          else if (miss_rd) state_d = S_RD;
          else              state_d = S_IDLE;
        end
      end
      S_WB: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = wb_addr_q;
        mem.mem_wdata = wb_data_q;
        if (mem.mem_ack) begin
          wb_done = 1'b1;
          state_d = miss_rd_q ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        state_d = S_RD;
      end
      S_RD: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = miss_addr_q;
        if (mem.mem_ack) begin
          fill_data_d = mem.mem_rdata;
          fill_addr_d = miss_addr_q;
          state_d     = S_FILL;
        end
      end
      S_FILL: begin
        fill_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Saturating performance counters; clear wins over a same-cycle increment.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (cnt_clr) begin
      miss_cnt_d = '0;
      wb_cnt_d   = '0;
    end else begin
      if (miss_accept && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 1'b1;
      if (wb_done && (wb_cnt_q != '1))       wb_cnt_d   = wb_cnt_q + 1'b1;
    end
  end

  assign fill_addr = fill_addr_q;
  assign fill_data = fill_data_q;
  assign miss_cnt  = miss_cnt_q;
  assign wb_cnt    = wb_cnt_q;

endmodule
